// File: rtl/scan_test_ctrl_pkg.sv
// rtl/scan_test_ctrl_pkg.sv - shared types and sizes for the scan-test sequencer
//
// Purpose: FSM state encoding, shift-counter width and latched-pattern record
//          used by scan_test_ctrl and scan_resp_cmp.
//          The record fields are sized from the PKG_* values, which are also
//          the default values of the scan_test_ctrl parameters.
// Ports:   none (package).
package scan_test_ctrl_pkg;

  localparam int PKG_N_PI = 4;
  localparam int PKG_N_PO = 1;
  localparam int PKG_N_FF = 3;

  // The counter indexes shift cycles 0..N_FF-1; the extra headroom keeps
  // N_FF=1 at a legal one-bit width.
  localparam int SCNT_W = $clog2(PKG_N_FF + 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    REPORT
  } state_t;

  typedef struct packed {
    logic [PKG_N_PI-1:0] pi;
    logic [PKG_N_FF-1:0] si;
    logic [PKG_N_PO-1:0] epo;
    logic [PKG_N_FF-1:0] eff;
  } pat_t;

endpackage

// File: rtl/scan_resp_cmp.sv
// rtl/scan_resp_cmp.sv - response comparator for one scan pattern
//
// Purpose: flags a pattern as failing when the sampled PO or the shifted-out
//          captured state differs from the expected values.  Kept on its own
//          so per-bit masking or X handling can be added here later.
// Ports:   po_smp/epo - sampled and expected primary outputs
//          obs/eff    - observed and expected captured state
//          fail       - 1 on any mismatch
module scan_resp_cmp
  import scan_test_ctrl_pkg::*;
#(
  parameter int N_PO = PKG_N_PO,
  parameter int N_FF = PKG_N_FF
) (
  input  logic [N_PO-1:0] po_smp,
  input  logic [N_PO-1:0] epo,
  input  logic [N_FF-1:0] obs,
  input  logic [N_FF-1:0] eff,
  output logic            fail
);

  assign fail = (po_smp != epo) | (obs != eff);

endmodule

// File: rtl/scan_test_ctrl.sv
// rtl/scan_test_ctrl.sv - mux-scan test sequencer: shift-in, capture, shift-out, compare
//
// Purpose: accepts one pattern per PAT_VLD/PAT_RDY handshake, scans the state
//          in, pulses one capture cycle, scans the response out and reports
//          pass/fail on the RES_VLD/RES_RDY handshake.  Keeps saturating
//          pattern and fail counters.  All outputs are registered.
// Ports:   CK, RST                  - clock, synchronous active-high reset
//          PAT_VLD/PAT_RDY/PAT_*    - pattern input handshake and fields
//          ABORT                    - drop the pattern in flight
//          SE/SI/SO/CE/PI/PO        - scan chain and circuit interface
//          RES_VLD/RES_RDY/RES_*    - result handshake and fields
//          PAT_CNT/FAIL_CNT         - completed / failing pattern counters
// Macro:   SCAN_TEST_CTRL_FIRST_FAIL_EN adds FIRST_FAIL_VLD/FIRST_FAIL_IDX,
//          the PAT_CNT value of the first failing pattern since reset.
module scan_test_ctrl
  import scan_test_ctrl_pkg::*;
#(
  parameter int N_PI  = PKG_N_PI,
  parameter int N_PO  = PKG_N_PO,
  parameter int N_FF  = PKG_N_FF,
  parameter int CNT_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             PAT_VLD,
  output logic             PAT_RDY,
  input  logic [N_PI-1:0]  PAT_PI,
  input  logic [N_FF-1:0]  PAT_SI,
  input  logic [N_PO-1:0]  PAT_EPO,
  input  logic [N_FF-1:0]  PAT_EFF,
  input  logic             ABORT,
  output logic             SE,
  output logic             SI,
  input  logic             SO,
  output logic             CE,
  output logic [N_PI-1:0]  PI,
  input  logic [N_PO-1:0]  PO,
  output logic             RES_VLD,
  input  logic             RES_RDY,
  output logic             RES_FAIL,
  output logic [N_FF-1:0]  RES_OBS,
  output logic [CNT_W-1:0] PAT_CNT,
  output logic [CNT_W-1:0] FAIL_CNT
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
  ,
  output logic             FIRST_FAIL_VLD,
  output logic [CNT_W-1:0] FIRST_FAIL_IDX
`endif
);

  state_t            state, state_d;
  pat_t              pat, pat_d;
  logic [SCNT_W-1:0] cnt, cnt_d;
  logic [N_PO-1:0]   po_smp, po_smp_d;
  logic [N_FF-1:0]   obs, obs_d, obs_ins;
  logic              se_d, si_d, ce_d, pat_rdy_d;
  logic              res_vld_d, res_fail_d;
  logic [N_FF-1:0]   res_obs_d;
  logic [N_PI-1:0]   pi_d;
  logic [CNT_W-1:0]  pat_cnt_d, fail_cnt_d;
  logic              last_shift;
  logic              cmp_fail;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
  logic              ff_vld_d;
  logic [CNT_W-1:0]  ff_idx_d;
`endif

  assign last_shift = (cnt == SCNT_W'(N_FF - 1));

  // Observed vector including the bit arriving on SO this cycle, so the
  // final shift-out cycle can register a complete result.
  always_comb begin
    obs_ins      = obs;
    obs_ins[cnt] = SO;
  end

  scan_resp_cmp #(
    .N_PO (N_PO),
    .N_FF (N_FF)
  ) u_cmp (
    .po_smp (po_smp),
    .epo    (pat.epo),
    .obs    (obs_ins),
    .eff    (pat.eff),
    .fail   (cmp_fail)
  );

  always_comb begin
    state_d    = state;
    pat_d      = pat;
    cnt_d      = cnt;
    po_smp_d   = po_smp;
    obs_d      = obs;
    se_d       = SE;
    si_d       = SI;
    ce_d       = CE;
    pi_d       = PI;
    res_vld_d  = RES_VLD;
    res_fail_d = RES_FAIL;
    res_obs_d  = RES_OBS;
    pat_cnt_d  = PAT_CNT;
    fail_cnt_d = FAIL_CNT;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
    ff_vld_d   = FIRST_FAIL_VLD;
    ff_idx_d   = FIRST_FAIL_IDX;
`endif

    if (ABORT && state != IDLE) begin
      state_d   = IDLE;
      se_d      = 1'b0;
      si_d      = 1'b0;
      ce_d      = 1'b0;
      res_vld_d = 1'b0;
      pi_d      = '0;
    end else begin
      case (state)
        IDLE: begin
          // ABORT also blocks acceptance here, so a pattern offered in the
          // abort cycle is never taken.
          if (PAT_VLD && PAT_RDY && !ABORT) begin
            pat_d   = '{pi: PAT_PI, si: PAT_SI, epo: PAT_EPO, eff: PAT_EFF};
            cnt_d   = '0;
            state_d = SHIFT_IN;
            se_d    = 1'b1;
            si_d    = PAT_SI[0];
            pi_d    = PAT_PI;
          end
        end
        SHIFT_IN: begin
          pi_d = pat.pi;
          if (last_shift) begin
            state_d = CAPTURE;
            se_d    = 1'b0;
            si_d    = 1'b0;
            ce_d    = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
            si_d  = pat.si[cnt_d];
          end
        end
        CAPTURE: begin
          // PO still reflects the scanned-in state during this cycle.
          po_smp_d = PO;
          state_d  = SHIFT_OUT;
          ce_d     = 1'b0;
          se_d     = 1'b1;
          si_d     = 1'b0;
          cnt_d    = '0;
        end
        SHIFT_OUT: begin
          obs_d = obs_ins;
          if (last_shift) begin
            state_d    = REPORT;
            se_d       = 1'b0;
            res_vld_d  = 1'b1;
            res_obs_d  = obs_ins;
            res_fail_d = cmp_fail;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        REPORT: begin
          if (RES_RDY) begin
            state_d   = IDLE;
            res_vld_d = 1'b0;
            pi_d      = '0;
            if (!(&PAT_CNT)) pat_cnt_d = PAT_CNT + 1'b1;
            if (RES_FAIL && !(&FAIL_CNT)) fail_cnt_d = FAIL_CNT + 1'b1;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
            if (RES_FAIL && !FIRST_FAIL_VLD) begin
              ff_vld_d = 1'b1;
              ff_idx_d = PAT_CNT;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pat_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state    <= IDLE;
      pat      <= '0;
      cnt      <= '0;
      po_smp   <= '0;
      obs      <= '0;
      PAT_RDY  <= 1'b1;
      SE       <= 1'b0;
      SI       <= 1'b0;
      CE       <= 1'b0;
      PI       <= '0;
      RES_VLD  <= 1'b0;
      RES_FAIL <= 1'b0;
      RES_OBS  <= '0;
      PAT_CNT  <= '0;
      FAIL_CNT <= '0;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
      FIRST_FAIL_VLD <= 1'b0;
      FIRST_FAIL_IDX <= '0;
`endif
    end else begin
      state    <= state_d;
      pat      <= pat_d;
      cnt      <= cnt_d;
      po_smp   <= po_smp_d;
      obs      <= obs_d;
      PAT_RDY  <= pat_rdy_d;
      SE       <= se_d;
      SI       <= si_d;
      CE       <= ce_d;
      PI       <= pi_d;
      RES_VLD  <= res_vld_d;
      RES_FAIL <= res_fail_d;
      RES_OBS  <= res_obs_d;
      PAT_CNT  <= pat_cnt_d;
      FAIL_CNT <= fail_cnt_d;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
      FIRST_FAIL_VLD <= ff_vld_d;
      FIRST_FAIL_IDX <= ff_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_test_ctrl.sv
// tb/tb_scan_test_ctrl.sv - self-checking bench for scan_test_ctrl with a 3-FF scan circuit model
module tb_scan_test_ctrl;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic       CK = 1'b0;
  logic       RST, PAT_VLD, ABORT, RES_RDY;
  logic [3:0] PAT_PI;
  logic [2:0] PAT_SI, PAT_EFF;
  logic [0:0] PAT_EPO;
  logic       PAT_RDY, SE, SI, SO, CE, RES_VLD, RES_FAIL;
  logic [3:0] PI;
  logic [0:0] PO;
  logic [2:0] RES_OBS;
  logic [CW-1:0] PAT_CNT, FAIL_CNT;
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
  logic          FIRST_FAIL_VLD;
  logic [CW-1:0] FIRST_FAIL_IDX;
`endif

  always #5 CK = ~CK;

  scan_test_ctrl #(.N_PI(4), .N_PO(1), .N_FF(3), .CNT_W(CW)) dut (
    .CK(CK), .RST(RST), .PAT_VLD(PAT_VLD), .PAT_RDY(PAT_RDY), .PAT_PI(PAT_PI),
    .PAT_SI(PAT_SI), .PAT_EPO(PAT_EPO), .PAT_EFF(PAT_EFF), .ABORT(ABORT),
    .SE(SE), .SI(SI), .SO(SO), .CE(CE), .PI(PI), .PO(PO),
    .RES_VLD(RES_VLD), .RES_RDY(RES_RDY), .RES_FAIL(RES_FAIL), .RES_OBS(RES_OBS),
    .PAT_CNT(PAT_CNT), .FAIL_CNT(FAIL_CNT)
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
    , .FIRST_FAIL_VLD(FIRST_FAIL_VLD), .FIRST_FAIL_IDX(FIRST_FAIL_IDX)
`endif
  );

  // Circuit under test: state s (bit k is the bit scanned in at shift k).
  function automatic logic [2:0] circ_next(input logic [2:0] s, input logic [3:0] pi);
    return s ^ {pi[3], pi[1], pi[0]};
  endfunction
  function automatic logic circ_po(input logic [2:0] s, input logic [3:0] pi);
    return s[0] | pi[3];
  endfunction
  function automatic logic [2:0] rev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Mux-scan chain: ff[0] nearest SI, ff[2] drives SO.
  logic [2:0] ff = 3'b000;
  assign SO = ff[2];
  assign PO = circ_po(rev3(ff), PI);
  always @(posedge CK) begin
    if (SE) ff <= {ff[1:0], SI};
    else if (CE) ff <= rev3(circ_next(rev3(ff), PI));
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   pc = 0, fc = 0;
  logic m_ffv = 1'b0;
  int   m_ffi = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic chk_counters();
    chk("pat_cnt", 32'(PAT_CNT), pc);
    chk("fail_cnt", 32'(FAIL_CNT), fc);
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
    chk("first_fail_vld", 32'(FIRST_FAIL_VLD), 32'(m_ffv));
    if (m_ffv) chk("first_fail_idx", 32'(FIRST_FAIL_IDX), m_ffi);
`endif
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!PAT_RDY && n < 50) begin
      step();
      n++;
    end
    chk("pat_rdy_wait", 32'(PAT_RDY), 1);
  endtask

  task automatic run_pat(input logic [3:0] pi, input logic [2:0] si, input logic epo,
                         input logic [2:0] eff, input int stall,
                         input logic [2:0] x_obs, input logic x_fail);
    wait_rdy();
    PAT_VLD = 1'b1; PAT_PI = pi; PAT_SI = si; PAT_EPO = epo; PAT_EFF = eff;
    RES_RDY = 1'b0;
    step();
    PAT_VLD = 1'b0; PAT_PI = 4'($urandom); PAT_SI = 3'($urandom);
    PAT_EPO = 1'($urandom); PAT_EFF = 3'($urandom);
    for (int k = 0; k < 3; k++) begin
      chk("shin_se", 32'(SE), 1);
      chk("shin_si", 32'(SI), 32'(si[k]));
      chk("shin_ce", 32'(CE), 0);
      chk("shin_rdy", 32'(PAT_RDY), 0);
      chk("shin_pi", 32'(PI), 32'(pi));
      step();
    end
    chk("cap_se", 32'(SE), 0);
    chk("cap_ce", 32'(CE), 1);
    chk("cap_pi", 32'(PI), 32'(pi));
    step();
    for (int k = 0; k < 3; k++) begin
      chk("shout_se", 32'(SE), 1);
      chk("shout_si", 32'(SI), 0);
      chk("shout_ce", 32'(CE), 0);
      chk("shout_vld", 32'(RES_VLD), 0);
      step();
    end
    chk("res_vld", 32'(RES_VLD), 1);
    chk("res_fail", 32'(RES_FAIL), 32'(x_fail));
    chk("res_obs", 32'(RES_OBS), 32'(x_obs));
    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_vld", 32'(RES_VLD), 1);
      chk("stall_fail", 32'(RES_FAIL), 32'(x_fail));
      chk("stall_obs", 32'(RES_OBS), 32'(x_obs));
      chk("stall_rdy", 32'(PAT_RDY), 0);
      chk("stall_se_ce", 32'({SE, CE}), 0);
      chk("stall_cnt", 32'(PAT_CNT), pc);
    end
    RES_RDY = 1'b1;
    step();
    RES_RDY = 1'b0;
    if (x_fail && !m_ffv) begin
      m_ffv = 1'b1;
      m_ffi = pc;
    end
    if (pc < CMAX) pc++;
    if (x_fail && fc < CMAX) fc++;
    chk("done_vld", 32'(RES_VLD), 0);
    chk("done_rdy", 32'(PAT_RDY), 1);
    chk("done_se", 32'(SE), 0);
    chk_counters();
  endtask

  typedef struct {
    logic [3:0] pi;
    logic [2:0] si;
    logic       epo;
    logic [2:0] eff;
    int         stall;
    logic [2:0] x_obs;
    logic       x_fail;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{pi: 4'b1010, si: 3'b101, epo: 1'b1, eff: 3'b011, stall: 0, x_obs: 3'b011, x_fail: 1'b0};
    tbl[1] = '{pi: 4'b1010, si: 3'b101, epo: 1'b1, eff: 3'b111, stall: 0, x_obs: 3'b011, x_fail: 1'b1};
    tbl[2] = '{pi: 4'b0110, si: 3'b011, epo: 1'b0, eff: 3'b001, stall: 5, x_obs: 3'b001, x_fail: 1'b1};
    tbl[3] = '{pi: 4'b1111, si: 3'b000, epo: 1'b1, eff: 3'b111, stall: 2, x_obs: 3'b111, x_fail: 1'b0};

    RST = 1'b1; PAT_VLD = 1'b0; ABORT = 1'b0; RES_RDY = 1'b0;
    PAT_PI = '0; PAT_SI = '0; PAT_EPO = '0; PAT_EFF = '0;
    repeat (3) step();
    chk("rst_outs", 32'({SE, SI, CE, PI, RES_VLD, RES_FAIL, RES_OBS}), 0);
    chk("rst_rdy", 32'(PAT_RDY), 1);
    chk_counters();
    RST = 1'b0;
    step();
    chk("idle_rdy", 32'(PAT_RDY), 1);

    // Table-driven directed patterns.
    for (int i = 0; i < 4; i++)
      run_pat(tbl[i].pi, tbl[i].si, tbl[i].epo, tbl[i].eff, tbl[i].stall, tbl[i].x_obs, tbl[i].x_fail);

    // ABORT in the second shift-in cycle with a new pattern offered.
    wait_rdy();
    PAT_VLD = 1'b1; PAT_PI = 4'b1010; PAT_SI = 3'b101; PAT_EPO = 1'b1; PAT_EFF = 3'b011;
    step();
    PAT_VLD = 1'b0;
    step();
    chk("abort_pre_se", 32'(SE), 1);
    ABORT = 1'b1; PAT_VLD = 1'b1;
    step();
    ABORT = 1'b0; PAT_VLD = 1'b0;
    chk("abort_se_ce", 32'({SE, CE}), 0);
    chk("abort_vld", 32'(RES_VLD), 0);
    chk("abort_rdy", 32'(PAT_RDY), 1);
    step();
    chk("abort_noaccept_rdy", 32'(PAT_RDY), 1);
    chk("abort_noaccept_se", 32'(SE), 0);
    chk_counters();
    run_pat(4'b1010, 3'b101, 1'b1, 3'b011, 0, 3'b011, 1'b0);

    // Reset during the capture cycle.
    wait_rdy();
    PAT_VLD = 1'b1; PAT_PI = 4'b1010; PAT_SI = 3'b101; PAT_EPO = 1'b1; PAT_EFF = 3'b111;
    step();
    PAT_VLD = 1'b0;
    repeat (3) step();
    chk("pre_rst_ce", 32'(CE), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    pc = 0; fc = 0; m_ffv = 1'b0; m_ffi = 0;
    chk("midrst_outs", 32'({SE, SI, CE, PI, RES_VLD, RES_FAIL, RES_OBS}), 0);
    chk("midrst_rdy", 32'(PAT_RDY), 1);
    chk_counters();

    // Saturation: five failing patterns into 2-bit counters.
    for (int i = 0; i < 5; i++)
      run_pat(4'b1010, 3'b101, 1'b1, 3'b111, 0, 3'b011, 1'b1);
    chk("sat_pat_cnt", 32'(PAT_CNT), 3);
    chk("sat_fail_cnt", 32'(FAIL_CNT), 3);
`ifdef SCAN_TEST_CTRL_FIRST_FAIL_EN
    chk("sat_ff_vld", 32'(FIRST_FAIL_VLD), 1);
    chk("sat_ff_idx", 32'(FIRST_FAIL_IDX), 0);
`endif

    // Randomized patterns against the circuit-level reference.
    RST = 1'b1;
    step();
    RST = 1'b0;
    pc = 0; fc = 0; m_ffv = 1'b0; m_ffi = 0;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] pi;
      logic [2:0] si, xo, eff;
      logic       xp, epo;
      pi  = 4'($urandom);
      si  = 3'($urandom);
      xo  = circ_next(si, pi);
      xp  = circ_po(si, pi);
      epo = ($urandom_range(0, 3) == 0) ? ~xp : xp;
      eff = ($urandom_range(0, 2) == 0) ? 3'($urandom) : xo;
      run_pat(pi, si, epo, eff, $urandom_range(0, 3), xo, (epo != xp) || (eff != xo));
      if (i == 3) begin
        RST = 1'b1;
        step();
        RST = 1'b0;
        pc = 0; fc = 0; m_ffv = 1'b0; m_ffi = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
